// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a hardware clear sweep.
// Entry 0 is hardwired to zero. After reset, or on CLR, the array is zeroed
// one entry per cycle; READY is low during the sweep and DONE pulses once
// when it completes.
//
// Ports:
//   CLK    in   clock, rising edge
//   RST    in   asynchronous active-low reset
//   CLR    in   synchronous request to clear the whole array
//   WE     in   write enable (honoured only in RUN, never to entry 0)
//   WADR   in   [ADDR_W]       write address
//   WDATA  in   [DATA_W]       write data
//   RADR   in   [NRD*ADDR_W]   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   RDATA  out  [NRD*DATA_W]   packed combinational read data with write-through bypass
//   READY  out  high while the array is usable (RUN)
//   DONE   out  one-cycle pulse after the last entry of a sweep is cleared
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CLR,
    input  logic                  WE,
    input  logic [ADDR_W-1:0]     WADR,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [NRD*ADDR_W-1:0] RADR,
    output logic [NRD*DATA_W-1:0] RDATA,
    output logic                  READY,
    output logic                  DONE
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                done_q, done_d;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wadr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                byp_en;

    logic [DATA_W-1:0]   mem [DEPTH];

    // State register: reset abandons any sweep or run activity at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    // Next state: CLR always (re)starts the sweep from entry 0 and defers DONE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                if (CLR) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST) begin
                    state_d = S_RUN;
                    ptr_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            S_RUN: begin
                if (CLR) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    // Outputs and array write port: sweep writes zero, RUN writes user data.
    always_comb begin
        READY     = 1'b0;
        mem_we    = 1'b0;
        mem_wadr  = WADR;
        mem_wdata = WDATA;
        byp_en    = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_wadr  = ptr_q;
                mem_wdata = '0;
            end
            S_RUN: begin
                READY = 1'b1;
                if (WE && !CLR && (WADR != '0)) begin
                    mem_we = 1'b1;
                    byp_en = 1'b1;
                end
            end
        endcase
    end

    assign DONE = done_q;

    // Storage: contents are not reset; the sweep zeroes them.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_wadr] <= mem_wdata;
        end
    end

    // Read ports: zero outside RUN and for entry 0, bypass on a same-address write.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] radr_k;
        logic [DATA_W-1:0] rdata_k;

        assign radr_k = RADR[k*ADDR_W +: ADDR_W];

        always_comb begin
            rdata_k = '0;
            if (READY && (radr_k != '0)) begin
                if (byp_en && (WADR == radr_k)) begin
                    rdata_k = WDATA;
                end else begin
                    rdata_k = mem[radr_k];
                end
            end
        end

        assign RDATA[k*DATA_W +: DATA_W] = rdata_k;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plus randomized checks of regfile_mp against an
// array-based reference model (DATA_W=32, ADDR_W=5, NRD=2).
module tb_regfile_mp;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NRD    = 2;
    localparam int unsigned DEPTH  = 32;

    logic                  CLK   = 1'b0;
    logic                  RST   = 1'b0;
    logic                  CLR   = 1'b0;
    logic                  WE    = 1'b0;
    logic [ADDR_W-1:0]     WADR  = '0;
    logic [DATA_W-1:0]     WDATA = '0;
    logic [NRD*ADDR_W-1:0] RADR  = '0;
    logic [NRD*DATA_W-1:0] RDATA;
    logic                  READY;
    logic                  DONE;

    int checks = 0;
    int errors = 0;

    // Reference model: contents, usable flag, done pulse, entries swept so far.
    logic [DATA_W-1:0] mem_m [DEPTH];
    bit                ready_m = 1'b0;
    bit                done_m  = 1'b0;
    int                swept   = 0;

    regfile_mp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NRD    (NRD)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .CLR   (CLR),
        .WE    (WE),
        .WADR  (WADR),
        .WDATA (WDATA),
        .RADR  (RADR),
        .RDATA (RDATA),
        .READY (READY),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [ADDR_W-1:0] a);
        if (!ready_m || a == 0) return 32'd0;
        if (WE && !CLR && WADR != 0 && WADR == a) return WDATA;
        return mem_m[a];
    endfunction

    task automatic check_all(input string tag);
        #1;
        check({tag, ".ready"}, 32'(READY), 32'(ready_m));
        check({tag, ".done"},  32'(DONE),  32'(done_m));
        check({tag, ".rd0"},   RDATA[31:0],  exp_rd(RADR[4:0]));
        check({tag, ".rd1"},   RDATA[63:32], exp_rd(RADR[9:5]));
    endtask

    // Advance the model by one rising edge using the inputs now applied, then clock the DUT.
    task automatic tick();
        if (RST) begin
            done_m = 1'b0;
            if (!ready_m) begin
                if (CLR) begin
                    swept = 0;
                end else begin
                    swept++;
                    if (swept == DEPTH) begin
                        ready_m = 1'b1;
                        done_m  = 1'b1;
                        foreach (mem_m[i]) mem_m[i] = '0;
                    end
                end
            end else if (CLR) begin
                ready_m = 1'b0;
                swept   = 0;
            end else if (WE && WADR != 0) begin
                mem_m[WADR] = WDATA;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST     = 1'b0;
        ready_m = 1'b0;
        done_m  = 1'b0;
        swept   = 0;
    endtask

    task automatic idle();
        CLR   = 1'b0;
        WE    = 1'b0;
        WADR  = '0;
        WDATA = '0;
    endtask

    task automatic sweep_wait(input string tag);
        for (int i = 0; i < int'(DEPTH); i++) begin
            check_all(tag);
            tick();
        end
        check_all({tag, "_end"});
    endtask

    initial begin
        // Reset held low.
        RADR = {5'd10, 5'd23};
        tick();
        tick();
        check_all("reset");

        // Release away from the edge; 32 edges of sweep, then RUN with a DONE pulse.
        RST = 1'b1;
        sweep_wait("init_sweep");
        check("init_ready_up", 32'(READY), 32'd1);
        check("init_done_up",  32'(DONE),  32'd1);
        tick();
        check_all("done_drop");
        for (int a = 0; a < int'(DEPTH); a++) begin
            RADR = {5'(a), 5'(DEPTH - 1 - a)};
            check_all("init_zero");
        end

        // Two writes then a two-port read.
        WE = 1'b1; WADR = 5'd10; WDATA = 32'd86332;
        tick();
        WADR = 5'd11; WDATA = 32'd26221;
        tick();
        idle();
        RADR = {5'd11, 5'd10};
        check_all("wr_rd");
        check("rd_r11", RDATA[63:32], 32'd26221);
        check("rd_r10", RDATA[31:0],  32'd86332);

        // Write-through bypass on both ports.
        WE = 1'b1; WADR = 5'd9; WDATA = 32'd17;
        RADR = {5'd9, 5'd9};
        check_all("bypass_pre");
        check("bypass_17", RDATA[31:0], 32'd17);
        tick();
        idle();
        check_all("bypass_post");

        // Writes to entry 0 are discarded.
        WE = 1'b1; WADR = 5'd0; WDATA = 32'hFFFF_FFFF;
        RADR = {5'd0, 5'd0};
        check_all("r0_pre");
        tick();
        idle();
        check_all("r0_post");

        // Randomized traffic with occasional clears.
        for (int n = 0; n < 400; n++) begin
            logic [ADDR_W-1:0] r0, r1;
            WE    = 1'($urandom_range(0, 1));
            WADR  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            WDATA = $urandom;
            CLR   = ($urandom_range(0, 59) == 0);
            r0    = ($urandom_range(0, 2) == 0) ? WADR : 5'($urandom_range(0, 31));
            r1    = ($urandom_range(0, 2) == 0) ? WADR : 5'($urandom_range(0, 31));
            RADR  = {r1, r0};
            check_all("rand");
            tick();
        end
        idle();
        for (int i = 0; i < 40 && !ready_m; i++) tick();
        check("settle_ready", 32'(READY), 32'd1);

        // CLR wins over a same-cycle write; array reads zero after the sweep.
        WE = 1'b1; WADR = 5'd10; WDATA = 32'd86332;
        tick();
        CLR = 1'b1; WE = 1'b1; WADR = 5'd23; WDATA = 32'd23;
        RADR = {5'd23, 5'd10};
        tick();
        idle();
        sweep_wait("clr_sweep");
        check("clr_done", 32'(DONE), 32'd1);
        check("clr_r10",  RDATA[31:0],  32'd0);
        check("clr_r23",  RDATA[63:32], 32'd0);
        tick();

        // Restart by CLR at sweep cycle 10, then by RST at sweep cycle 20.
        CLR = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 10; i++) begin check_all("pre_restart"); tick(); end
        CLR = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 20; i++) begin check_all("pre_rst"); tick(); end
        apply_reset();
        check_all("rst_mid_sweep");
        tick();
        RST = 1'b1;
        sweep_wait("restart_sweep");
        check("restart_done", 32'(DONE), 32'd1);
        tick();

        // Reset in RUN takes effect without a clock edge.
        WE = 1'b1; WADR = 5'd5; WDATA = 32'hA5A5_0001;
        tick();
        idle();
        RADR = {5'd5, 5'd5};
        check_all("run_before_rst");
        apply_reset();
        check_all("rst_in_run");
        check("rst_ready_async", 32'(READY), 32'd0);
        tick();
        check_all("rst_hold");
        RST = 1'b1;
        sweep_wait("final_sweep");
        tick();
        check_all("final_run");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
